// File: rtl/reflet_float_mult_pipe_pkg.sv
// Shared float helpers for the Reflet FPU: field sizes, operand classes,
// canonical NaN and status flag bundle.
package reflet_float_mult_pipe_pkg;

  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_NORM = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  typedef struct packed {
    logic invalid;
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

  function automatic int mantissa_size(input int float_size);
    case (float_size)
      16:      return 10;
      64:      return 52;
      default: return 23;
    endcase
  endfunction

  function automatic int exponent_size(input int float_size);
    case (float_size)
      16:      return 5;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int exponent_bias(input int float_size);
    return (1 << (exponent_size(float_size) - 1)) - 1;
  endfunction

  function automatic int exp_all_ones(input int float_size);
    return (1 << exponent_size(float_size)) - 1;
  endfunction

  // Sign 0, exponent all ones, mantissa MSB set: E+1 ones starting at bit M-1.
  function automatic logic [63:0] qnan(input int float_size);
    logic [63:0] ones;
    ones = (64'd1 << (exponent_size(float_size) + 1)) - 64'd1;
    return ones << (mantissa_size(float_size) - 1);
  endfunction

endpackage

// File: rtl/reflet_float_mult_mult.sv
// Unsigned mantissa multiplier; purely combinational, caller registers.
module reflet_float_mult_mult #(
  parameter int width = 24
) (
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  output logic [2*width-1:0] p
);

  assign p = a * b;

endmodule

// File: rtl/reflet_float_round_pack.sv
// Normalise a raw mantissa product, round to nearest-even and pack the result
// together with special-class overrides and status flags.
module reflet_float_round_pack
  import reflet_float_mult_pipe_pkg::*;
#(
  parameter int float_size = 32
) (
  input  logic                                sign,
  input  logic [1:0]                          cls,
  input  logic signed [exponent_size(float_size)+1:0] e,
  input  logic [2*mantissa_size(float_size)+1:0]      prod,
  output logic [float_size-1:0]               result,
  output flags_t                              flags
);

  localparam int M  = mantissa_size(float_size);
  localparam int E  = exponent_size(float_size);
  localparam int EW = E + 2;
  localparam int P  = 2 * (M + 1);
  localparam logic [E-1:0] EXP_ONES = E'(exp_all_ones(float_size));
  localparam logic signed [EW-1:0] EXP_MAX = EW'(exp_all_ones(float_size));
  localparam logic signed [EW-1:0] E_ZERO  = '0;
  localparam logic signed [EW-1:0] E_ONE   = EW'(1);
  localparam logic [float_size-1:0] QNAN   = float_size'(qnan(float_size));

  logic [M-1:0] frac;
  logic [M-1:0] frac_r;
  logic [M:0]   sum;
  logic         g;
  logic         st;
  logic         up;
  logic signed [EW-1:0] e_n;
  logic signed [EW-1:0] e_r;

  always_comb begin
    frac   = '0;
    g      = 1'b0;
    st     = 1'b0;
    e_n    = e;
    if (prod[P-1]) begin
      frac = prod[P-2 -: M];
      g    = prod[M];
      st   = |prod[M-1:0];
      e_n  = e + E_ONE;
    end else begin
      frac = prod[P-3 -: M];
      g    = prod[M-1];
      st   = |prod[M-2:0];
    end
    up     = g & (st | frac[0]);
    sum    = {1'b0, frac} + {{M{1'b0}}, up};
    // A carry out of the fraction leaves it all-zero and bumps the exponent.
    frac_r = sum[M-1:0];
    e_r    = sum[M] ? e_n + E_ONE : e_n;

    result = '0;
    flags  = '0;
    case (cls)
      CLS_NAN: begin
        result        = QNAN;
        flags.invalid = 1'b1;
      end
      CLS_INF:  result = {sign, EXP_ONES, {M{1'b0}}};
      CLS_ZERO: result = {sign, {(float_size-1){1'b0}}};
      default: begin
        if (e_r >= EXP_MAX) begin
          result         = {sign, EXP_ONES, {M{1'b0}}};
          flags.overflow = 1'b1;
          flags.inexact  = 1'b1;
        end else if (e_r <= E_ZERO) begin
          result          = {sign, {(float_size-1){1'b0}}};
          flags.underflow = 1'b1;
          flags.inexact   = 1'b1;
        end else begin
          result        = {sign, e_r[E-1:0], frac_r};
          flags.inexact = g | st;
        end
      end
    endcase
  end

endmodule

// File: rtl/reflet_float_mult_pipe.sv
// Three-stage float multiplier: unpack/classify, mantissa multiply,
// normalise/round/pack.
module reflet_float_mult_pipe
  import reflet_float_mult_pipe_pkg::*;
#(
  parameter int float_size = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [float_size-1:0] in1,
  input  logic [float_size-1:0] in2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [float_size-1:0] mult,
  output logic                  flag_invalid,
  output logic                  flag_overflow,
  output logic                  flag_underflow,
  output logic                  flag_inexact
);

  localparam int M  = mantissa_size(float_size);
  localparam int E  = exponent_size(float_size);
  localparam int EW = E + 2;
  localparam int P  = 2 * (M + 1);
  localparam logic [E-1:0] EXP_ONES = E'(exp_all_ones(float_size));
  localparam logic signed [EW-1:0] BIAS_S = EW'(exponent_bias(float_size));

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high. The whole pipe moves together whenever the output slot is empty or
  // being drained, so in_ready never depends on in_valid.
  logic advance;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  logic [E-1:0] exp1, exp2;
  logic [M-1:0] mnt1, mnt2;
  logic zero1, zero2, inf1, inf2, nan1, nan2;
  logic [1:0] cls_c;
  logic signed [EW-1:0] e_sum;

  assign exp1  = in1[float_size-2:M];
  assign exp2  = in2[float_size-2:M];
  assign mnt1  = in1[M-1:0];
  assign mnt2  = in2[M-1:0];
  assign zero1 = (exp1 == '0);
  assign zero2 = (exp2 == '0);
  assign inf1  = (exp1 == EXP_ONES) && (mnt1 == '0);
  assign inf2  = (exp2 == EXP_ONES) && (mnt2 == '0);
  assign nan1  = (exp1 == EXP_ONES) && (mnt1 != '0);
  assign nan2  = (exp2 == EXP_ONES) && (mnt2 != '0);
  assign e_sum = $signed({2'b00, exp1}) + $signed({2'b00, exp2}) - BIAS_S;

  // Combined class, resolved once so later stages only carry two bits.
  always_comb begin
    cls_c = CLS_NORM;
    if (nan1 || nan2 || (inf1 && zero2) || (inf2 && zero1)) cls_c = CLS_NAN;
    else if (inf1 || inf2)                                  cls_c = CLS_INF;
    else if (zero1 || zero2)                                cls_c = CLS_ZERO;
  end

  logic                 s1_valid, s1_sign;
  logic [1:0]           s1_cls;
  logic signed [EW-1:0] s1_e;
  logic [M-1:0]         s1_m1, s1_m2;

  logic                 s2_valid, s2_sign;
  logic [1:0]           s2_cls;
  logic signed [EW-1:0] s2_e;
  logic [P-1:0]         s2_prod;

  logic [P-1:0]          prod_c;
  logic [float_size-1:0] pack_result;
  flags_t                pack_flags;

  reflet_float_mult_mult #(.width(M + 1)) u_mult (
    .a ({1'b1, s1_m1}),
    .b ({1'b1, s1_m2}),
    .p (prod_c)
  );

  reflet_float_round_pack #(.float_size(float_size)) u_round_pack (
    .sign   (s2_sign),
    .cls    (s2_cls),
    .e      (s2_e),
    .prod   (s2_prod),
    .result (pack_result),
    .flags  (pack_flags)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid       <= 1'b0;
      s1_sign        <= 1'b0;
      s1_cls         <= CLS_ZERO;
      s1_e           <= '0;
      s1_m1          <= '0;
      s1_m2          <= '0;
      s2_valid       <= 1'b0;
      s2_sign        <= 1'b0;
      s2_cls         <= CLS_ZERO;
      s2_e           <= '0;
      s2_prod        <= '0;
      out_valid      <= 1'b0;
      mult           <= '0;
      flag_invalid   <= 1'b0;
      flag_overflow  <= 1'b0;
      flag_underflow <= 1'b0;
      flag_inexact   <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (in_valid) begin
        s1_sign <= in1[float_size-1] ^ in2[float_size-1];
        s1_cls  <= cls_c;
        s1_e    <= e_sum;
        s1_m1   <= mnt1;
        s1_m2   <= mnt2;
      end
      if (s1_valid) begin
        s2_sign <= s1_sign;
        s2_cls  <= s1_cls;
        s2_e    <= s1_e;
        s2_prod <= prod_c;
      end
      // Outputs only change on a real result, so bubbles leave mult stable.
      if (s2_valid) begin
        mult           <= pack_result;
        flag_invalid   <= pack_flags.invalid;
        flag_overflow  <= pack_flags.overflow;
        flag_underflow <= pack_flags.underflow;
        flag_inexact   <= pack_flags.inexact;
      end
    end
  end

endmodule

// File: tb/tb_reflet_float_mult_pipe.sv
// Bench for reflet_float_mult_pipe: directed corner cases, backpressure, reset
// flush and a random stream scored against an integer-arithmetic float model.
module tb_reflet_float_mult_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in1, in2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] mult;
  logic        flag_invalid, flag_overflow, flag_underflow, flag_inexact;

  logic        h_valid, h_in_ready, h_out_valid, h_out_ready;
  logic [15:0] h_in1, h_in2, h_mult;
  logic        h_inv, h_ovf, h_unf, h_inx;

  int total = 0;
  int bad   = 0;
  logic [35:0] exp_q[$];

  reflet_float_mult_pipe #(.float_size(32)) dut (
    .clk (clk), .reset (reset),
    .in_valid (in_valid), .in_ready (in_ready), .in1 (in1), .in2 (in2),
    .out_valid (out_valid), .out_ready (out_ready), .mult (mult),
    .flag_invalid (flag_invalid), .flag_overflow (flag_overflow),
    .flag_underflow (flag_underflow), .flag_inexact (flag_inexact)
  );

  reflet_float_mult_pipe #(.float_size(16)) dut16 (
    .clk (clk), .reset (reset),
    .in_valid (h_valid), .in_ready (h_in_ready), .in1 (h_in1), .in2 (h_in2),
    .out_valid (h_out_valid), .out_ready (h_out_ready), .mult (h_mult),
    .flag_invalid (h_inv), .flag_overflow (h_ovf),
    .flag_underflow (h_unf), .flag_inexact (h_inx)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product, rounding by remainder against one half.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    longint ma, mb, prod, q, rem, half;
    logic s;
    bit za, zb, ia, ib, na, nb;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'(a[22:0]);
    mb = longint'(b[22:0]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (ma == 0);
    ib = (eb == 255) && (mb == 0);
    na = (ea == 255) && (ma != 0);
    nb = (eb == 255) && (mb != 0);
    if (na || nb || (ia && zb) || (ib && za)) return {32'h7FC00000, 4'b1000};
    if (ia || ib) return {s, 8'hFF, 23'h0, 4'b0000};
    if (za || zb) return {s, 31'h0, 4'b0000};
    prod = (ma + (64'd1 << 23)) * (mb + (64'd1 << 23));
    sh   = (prod >= (64'd1 << 47)) ? 24 : 23;
    q    = prod >> sh;
    rem  = prod - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    e = ea + eb - 127 + (sh - 23);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0, 4'b0101};
    if (e <= 0)   return {s, 31'h0, 4'b0011};
    return {s, 8'(e), 23'(q), 3'b000, (rem != 0)};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] m;
    int k;
    k = $urandom_range(0, 15);
    m = 23'($urandom);
    case (k)
      0:       e = 8'd0;
      1:       begin e = 8'hFF; m = 23'd0; end
      2:       begin e = 8'hFF; m = 23'($urandom_range(1, 32'h7FFFFF)); end
      3:       e = 8'($urandom_range(240, 254));
      4:       e = 8'($urandom_range(1, 15));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, m};
  endfunction

  // driver: leaves in_valid high so consecutive calls stream one per cycle
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [35:0] e);
    int n;
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_accept", 64'(in_ready), 64'd1);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic latency_probe(input string pfx, input logic [31:0] a, input logic [31:0] b,
                               input logic [35:0] e);
    exp_q.push_back(e);
    in1 = a;
    in2 = b;
    in_valid = 1'b1;
    @(negedge clk);
    check({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    h_valid  = 1'b0;
    check({pfx, "_c1"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check({pfx, "_c2"}, 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check({pfx, "_c3"}, 64'(out_valid), 64'd1);
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      check("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0)
        check("result", 64'({mult, flag_invalid, flag_overflow, flag_underflow, flag_inexact}),
              64'(exp_q.pop_front()));
    end
  end

  logic [31:0] dir_a[9] = '{32'h40000000, 32'hC0000000, 32'h3FC00000, 32'h3F800001,
                            32'h7F800000, 32'h7FC00001, 32'hFF800000, 32'h7F000000,
                            32'h00800000};
  logic [31:0] dir_b[9] = '{32'h40400000, 32'h40400000, 32'h3FC00000, 32'h3F800001,
                            32'h00000000, 32'h3F800000, 32'h40000000, 32'h7F000000,
                            32'h00800000};
  logic [35:0] dir_e[9] = '{{32'h40C00000, 4'b0000}, {32'hC0C00000, 4'b0000},
                            {32'h40100000, 4'b0000}, {32'h3F800002, 4'b0001},
                            {32'h7FC00000, 4'b1000}, {32'h7FC00000, 4'b1000},
                            {32'hFF800000, 4'b0000}, {32'h7F800000, 4'b0101},
                            {32'h00000000, 4'b0011}};

  logic [31:0] bp_a[4];
  logic [31:0] bp_b[4];
  logic [31:0] snap;
  int acc, sent, cyc;
  bit accepted;

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    out_ready = 1'b1;
    h_valid = 1'b0;
    h_in1 = '0;
    h_in2 = '0;
    h_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_mult", 64'(mult), 64'd0);
    check("rst_flags", 64'({flag_invalid, flag_overflow, flag_underflow, flag_inexact}), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // model sanity against hand-derived constants
    for (int i = 0; i < 9; i++) check("model_const", 64'(model(dir_a[i], dir_b[i])), 64'(dir_e[i]));

    // latency, with the half-precision instance alongside
    h_in1 = 16'h4000;
    h_in2 = 16'h4200;
    h_valid = 1'b1;
    latency_probe("lat", 32'h40000000, 32'h40400000, {32'h40C00000, 4'b0000});
    check("h16_valid", 64'(h_out_valid), 64'd1);
    check("h16_mult", 64'(h_mult), 64'h4600);
    check("h16_flags", 64'({h_inv, h_ovf, h_unf, h_inx}), 64'd0);
    repeat (2) @(posedge clk);
    #1;

    // directed corner cases streamed back to back
    for (int i = 0; i < 9; i++) send(dir_a[i], dir_b[i], dir_e[i]);
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // backpressure: four operands offered, only three fit
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 32'h40000000 + (32'(i) << 20);
      bp_b[i] = 32'h40400000 + (32'(i) << 18);
    end
    out_ready = 1'b0;
    acc = 0;
    snap = '0;
    for (int i = 0; i < 6; i++) begin
      in1 = bp_a[acc < 4 ? acc : 3];
      in2 = bp_b[acc < 4 ? acc : 3];
      in_valid = (acc < 4);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(bp_a[acc], bp_b[acc]));
        acc++;
      end
      @(posedge clk);
      #1;
      if (i == 3) snap = mult;
    end
    check("bp_accepted", 64'(acc), 64'd3);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_mult_stable", 64'(mult), 64'(snap));
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check("drain_valid", 64'(out_valid), 64'd1);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(bp_a[acc], bp_b[acc]));
        acc++;
      end
      @(posedge clk);
      #1;
      if (acc == 4) in_valid = 1'b0;
    end
    check("bp_accept_all", 64'(acc), 64'd4);
    repeat (5) @(posedge clk);
    #1;

    // reset while two operations are in flight
    send(32'h40400000, 32'h40400000, {32'h41100000, 4'b0000});
    send(32'h3FC00000, 32'h40000000, {32'h40400000, 4'b0000});
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_mult", 64'(mult), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    latency_probe("postrst", 32'h40000000, 32'h40400000, {32'h40C00000, 4'b0000});
    repeat (2) @(posedge clk);
    #1;

    // random stream with random backpressure
    sent = 0;
    cyc = 0;
    in_valid = 1'b0;
    while (sent < 300 && cyc < 5000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in1 = rand_op();
        in2 = rand_op();
        in_valid = 1'b1;
      end
      @(negedge clk);
      accepted = in_valid && in_ready;
      if (accepted) begin
        exp_q.push_back(model(in1, in2));
        sent++;
      end
      @(posedge clk);
      #1;
      if (accepted) in_valid = 1'b0;
      cyc++;
    end
    check("rand_sent", 64'(sent), 64'd300);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
